// File: rtl/spi_pkg.sv
// Shared SPI definitions: state encoding, byte width and default idle byte.
// Imported by both the SPI master and the SPI slave.
package spi_pkg;

  localparam int SPI_BYTE_W = 8;
  localparam logic [SPI_BYTE_W-1:0] SPI_IDLE_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    SPI_S_IDLE  = 2'd0,
    SPI_S_SHIFT = 2'd1,
    SPI_S_FLUSH = 2'd2
  } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for one asynchronous input.
// Provides the synchronized level and single-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/spi_slave_rx_tx.sv
// SPI responder (CPOL=0, CPHA=1, MSB first) with RX push and FWFT TX pop ports.
// Optional byte counter output enabled by defining SPI_SLAVE_BYTECNT_EN.
//
// state       | meaning
// SPI_S_IDLE  | no frame; waits for a cs falling edge
// SPI_S_SHIFT | frame active; shifts miso on sck rise, samples mosi on sck fall
// SPI_S_FLUSH | one cycle after cs rise; flags a partial byte, returns to idle
module spi_slave_rx_tx
  import spi_pkg::*;
#(
  parameter int                    SYNC_STAGES = 2,
  parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE   = SPI_IDLE_BYTE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  sck,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  output logic [SPI_BYTE_W-1:0] dout,
  output logic                  rx_fifo_wr,
  input  logic                  rx_fifo_full,
  input  logic [SPI_BYTE_W-1:0] din,
  output logic                  tx_fifo_rd,
  input  logic                  tx_fifo_empty,
  input  logic                  clr_err,
  output logic                  overrun,
  output logic                  underrun,
  output logic                  frame_err,
  output logic                  busy
`ifdef SPI_SLAVE_BYTECNT_EN
  ,
  output logic [7:0]            byte_cnt
`endif
);

  localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);

  logic cs_s, cs_rise, cs_fall;
  logic sck_lvl_unused, sck_rise, sck_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(cs), .q(cs_s), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .d(sck), .q(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  spi_state_t            state;
  logic [2:0]            bit_cnt;
  logic [SPI_BYTE_W-1:0] rx_sh;
  logic [SPI_BYTE_W-1:0] tx_sh;
  logic [SETTLE_W-1:0]   settle_cnt;
  logic                  armed;

  // The cs synchronizer resets high, so a cs already low at reset release
  // produces a false fall; frames are only accepted once cs is seen high
  // after the synchronizer has filled with real samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SPI_S_IDLE;
      bit_cnt    <= '0;
      rx_sh      <= '0;
      tx_sh      <= '0;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      dout       <= '0;
      rx_fifo_wr <= 1'b0;
      tx_fifo_rd <= 1'b0;
      overrun    <= 1'b0;
      underrun   <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
      settle_cnt <= SETTLE_W'(SYNC_STAGES + 1);
      armed      <= 1'b0;
`ifdef SPI_SLAVE_BYTECNT_EN
      byte_cnt   <= '0;
`endif
    end else begin
      rx_fifo_wr <= 1'b0;
      tx_fifo_rd <= 1'b0;
      if (settle_cnt != '0) settle_cnt <= settle_cnt - SETTLE_W'(1);
      else if (cs_s)        armed      <= 1'b1;

      if (clr_err) begin
        overrun   <= 1'b0;
        underrun  <= 1'b0;
        frame_err <= 1'b0;
      end

      case (state)
        SPI_S_IDLE: begin
          if (cs_fall && armed) begin
            state   <= SPI_S_SHIFT;
            miso_oe <= 1'b1;
            busy    <= 1'b1;
            bit_cnt <= '0;
`ifdef SPI_SLAVE_BYTECNT_EN
            byte_cnt <= '0;
`endif
          end
        end
        SPI_S_SHIFT: begin
          if (cs_rise) begin
            state   <= SPI_S_FLUSH;
            miso_oe <= 1'b0;
          end else begin
            if (sck_rise) begin
              if (bit_cnt == 3'd0) begin
                if (!tx_fifo_empty) begin
                  tx_sh      <= din;
                  miso       <= din[SPI_BYTE_W-1];
                  tx_fifo_rd <= 1'b1;
                end else begin
                  tx_sh    <= IDLE_BYTE;
                  miso     <= IDLE_BYTE[SPI_BYTE_W-1];
                  underrun <= 1'b1;
                end
              end else begin
                tx_sh <= {tx_sh[SPI_BYTE_W-2:0], 1'b0};
                miso  <= tx_sh[SPI_BYTE_W-2];
              end
            end
            if (sck_fall) begin
              rx_sh   <= {rx_sh[SPI_BYTE_W-2:0], mosi_s};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (rx_fifo_full) begin
                  overrun <= 1'b1;
                end else begin
                  dout       <= {rx_sh[SPI_BYTE_W-2:0], mosi_s};
                  rx_fifo_wr <= 1'b1;
                end
`ifdef SPI_SLAVE_BYTECNT_EN
                if (byte_cnt != 8'hFF) byte_cnt <= byte_cnt + 8'd1;
`endif
              end
            end
          end
        end
        SPI_S_FLUSH: begin
          if (bit_cnt != 3'd0) frame_err <= 1'b1;
          bit_cnt <= '0;
          miso    <= 1'b0;
          busy    <= 1'b0;
          state   <= SPI_S_IDLE;
        end
        default: begin
          state   <= SPI_S_IDLE;
          miso_oe <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Scoreboard bench for spi_slave_rx_tx: a bit-level SPI master model drives
// frames, expected RX pushes are queued and checked by a monitor process.
module tb_spi_slave_rx_tx;

  localparam int SS   = 2;
  localparam int HALF = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cs = 1'b1, sck = 1'b0, mosi = 1'b0;
  logic       miso, miso_oe, rx_fifo_wr, tx_fifo_rd, tx_fifo_empty;
  logic [7:0] dout, din;
  logic       rx_fifo_full = 1'b0, clr_err = 1'b0;
  logic       overrun, underrun, frame_err, busy;
`ifdef SPI_SLAVE_BYTECNT_EN
  logic [7:0] byte_cnt;
`endif

  always #5 clk = ~clk;

  spi_slave_rx_tx #(.SYNC_STAGES(SS), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .rst(rst), .cs(cs), .sck(sck), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .dout(dout), .rx_fifo_wr(rx_fifo_wr),
    .rx_fifo_full(rx_fifo_full), .din(din), .tx_fifo_rd(tx_fifo_rd),
    .tx_fifo_empty(tx_fifo_empty), .clr_err(clr_err), .overrun(overrun),
    .underrun(underrun), .frame_err(frame_err), .busy(busy)
`ifdef SPI_SLAVE_BYTECNT_EN
    , .byte_cnt(byte_cnt)
`endif
  );

  // TX FIFO model: stimulus owns the write side, this block the read side
  logic [7:0] tx_mem [16];
  logic [3:0] wr_ptr = 4'd0, rd_ptr = 4'd0;
  int         pops = 0;
  assign din           = tx_mem[rd_ptr];
  assign tx_fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (tx_fifo_rd) begin
      pops <= pops + 1;
      if (rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 4'd1;
    end
  end

  int         n_cmp = 0, n_bad = 0;
  logic [7:0] exp_rx [$];
  logic [7:0] m_tx [8];
  logic [7:0] m_rx [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_push(input logic [7:0] v);
    tx_mem[wr_ptr] = v;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1; wait_clk(1); clr_err = 1'b0; wait_clk(1);
  endtask

  task automatic sck_cycles(input int n, input logic [7:0] pat);
    for (int i = 0; i < n; i++) begin
      sck = 1'b1; mosi = pat[7 - (i % 8)]; wait_clk(HALF);
      sck = 1'b0; wait_clk(HALF);
    end
  endtask

  // Frame of nbytes; the last byte is cut to nbits; full_idx marks the byte
  // during which the RX FIFO reports full. Leaves cs high on return.
  task automatic spi_xfer(input int nbytes, input int nbits, input int full_idx);
    cs = 1'b0; wait_clk(HALF);
    for (int b = 0; b < nbytes; b++) begin
      rx_fifo_full = (b == full_idx);
      for (int i = 7; i >= 0; i--) begin
        if (b == nbytes - 1 && (7 - i) >= nbits) break;
        sck = 1'b1; mosi = m_tx[b][i]; wait_clk(HALF);
        m_rx[b][i] = miso; sck = 1'b0; wait_clk(HALF);
      end
`ifdef SPI_SLAVE_BYTECNT_EN
      if (b < nbytes - 1 || nbits == 8) check("byte_cnt_run", {24'd0, byte_cnt}, b + 1);
`endif
    end
    cs = 1'b1;
  endtask

  initial begin
    int p0;
    fork
      forever begin
        @(negedge clk);
        if (rx_fifo_wr) begin
          if (exp_rx.size() == 0) check("rx_push", {23'd0, 1'b1, dout}, 32'd0);
          else                    check("rx_push", {23'd0, 1'b1, dout}, {23'd0, 1'b1, exp_rx.pop_front()});
        end
      end
      begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
      end
    join_none

    // reset values
    wait_clk(3);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_outs", {26'd0, miso, miso_oe, rx_fifo_wr, tx_fifo_rd, overrun, underrun}, 0);
    check("rst_dout", {24'd0, dout}, 0);
    rst = 1'b1; wait_clk(10);
    check("idle_flags", {29'd0, overrun, underrun, frame_err}, 0);

    // single byte frame
    tx_push(8'hA5); m_tx[0] = 8'h3C; exp_rx.push_back(8'h3C);
    spi_xfer(1, 8, -1); wait_clk(10);
    check("t1_miso", {24'd0, m_rx[0]}, 32'hA5);
    check("t1_pops", pops, 1);
    check("t1_flags", {29'd0, overrun, underrun, frame_err}, 0);
    check("t1_rx_left", exp_rx.size(), 0);
    check("t1_busy", {30'd0, busy, miso_oe}, 0);

    // three bytes, TX FIFO runs dry on the third
    tx_push(8'h01); tx_push(8'h02);
    m_tx[0] = 8'h10; m_tx[1] = 8'h20; m_tx[2] = 8'h30;
    exp_rx.push_back(8'h10); exp_rx.push_back(8'h20); exp_rx.push_back(8'h30);
    spi_xfer(3, 8, -1); wait_clk(10);
    check("t2_miso0", {24'd0, m_rx[0]}, 32'h01);
    check("t2_miso1", {24'd0, m_rx[1]}, 32'h02);
    check("t2_miso2", {24'd0, m_rx[2]}, 32'hFF);
    check("t2_underrun", {31'd0, underrun}, 1);
    check("t2_pops", pops, 3);
    check("t2_rx_left", exp_rx.size(), 0);
    pulse_clr();
    check("t2_clr", {31'd0, underrun}, 0);

    // RX full during the second byte
    tx_push(8'h66); tx_push(8'h99);
    m_tx[0] = 8'h81; m_tx[1] = 8'h42; exp_rx.push_back(8'h81);
    spi_xfer(2, 8, 1); wait_clk(10); rx_fifo_full = 1'b0;
    check("t3_overrun", {31'd0, overrun}, 1);
    check("t3_miso1", {24'd0, m_rx[1]}, 32'h99);
    check("t3_rx_left", exp_rx.size(), 0);
    pulse_clr();
    check("t3_clr", {31'd0, overrun}, 0);

    // cs raised after 5 bits
    tx_push(8'hE7); m_tx[0] = 8'hAA;
    spi_xfer(1, 5, -1); wait_clk(SS + 3);
    check("t4_busy", {31'd0, busy}, 0);
    check("t4_frame_err", {31'd0, frame_err}, 1);
    wait_clk(5); pulse_clr();
    check("t4_clr", {31'd0, frame_err}, 0);
    tx_push(8'h5A); m_tx[0] = 8'h55; exp_rx.push_back(8'h55);
    spi_xfer(1, 8, -1); wait_clk(10);
    check("t4_miso", {24'd0, m_rx[0]}, 32'h5A);
    check("t4_rx_left", exp_rx.size(), 0);
    check("t4_flags", {29'd0, overrun, underrun, frame_err}, 0);

    // reset mid-byte with cs held low
    cs = 1'b0; wait_clk(HALF); sck_cycles(3, 8'hF0);
    sck = 1'b1; wait_clk(1); rst = 1'b0; #1;
    check("t5_rst_busy", {29'd0, busy, miso_oe, miso}, 0);
    wait_clk(2); sck = 1'b0; rst = 1'b1;
    p0 = pops; tx_push(8'h77);
    wait_clk(HALF); sck_cycles(8, 8'h5A);
    check("t5_idle", {29'd0, busy, miso_oe, underrun}, 0);
    check("t5_no_pop", pops, p0);
    cs = 1'b1; wait_clk(10);
    m_tx[0] = 8'hC3; exp_rx.push_back(8'hC3);
    spi_xfer(1, 8, -1); wait_clk(10);
    check("t5_miso", {24'd0, m_rx[0]}, 32'h77);
    check("t5_pops", pops, p0 + 1);
    check("t5_rx_left", exp_rx.size(), 0);

`ifdef SPI_SLAVE_BYTECNT_EN
    m_tx[0] = 8'h0F; m_tx[1] = 8'hF0; m_tx[2] = 8'h3A; m_tx[3] = 8'hC5;
    for (int i = 0; i < 4; i++) exp_rx.push_back(m_tx[i]);
    spi_xfer(4, 8, -1); wait_clk(10);
    check("bc_hold", {24'd0, byte_cnt}, 4);
    cs = 1'b0; wait_clk(SS + 4);
    check("bc_clear", {24'd0, byte_cnt}, 0);
    cs = 1'b1; wait_clk(10);
    check("bc_rx_left", exp_rx.size(), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
